pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall sequencer for the 5-stage MIPS pipeline. Merges stall requests from
//  ID (load-use) and EX (multi-cycle op) into the 6-bit stall bus, owns the ID
//  instruction hold buffer (replays the fetched word across a stall), tracks stall
//  episodes with an FSM, and keeps saturating stall counters plus a stall watchdog.
// PARAMETERS
//  PERF_W    16   width of each stall-cycle counter (saturating)
//  TIMEOUT   64   consecutive stall cycles before stall_timeout sets (>=2)
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset, synchronous, active-high
//  stallreq_id     in   1       ID load-use hazard request (combinational from ID)
//  stallreq_ex     in   1       EX busy request (e.g. div in progress)
//  inst_sram_rdata in   32      instruction SRAM read data
//  stall           out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1=Stop
//  id_inst         out  32      instruction to ID decode
//  stall_state     out  2       FSM state (debug)
//  cnt_id_stall    out  PERF_W  cycles spent in S_ID
//  cnt_ex_stall    out  PERF_W  cycles spent in S_EX
//  stall_timeout   out  1       sticky watchdog flag
// BEHAVIOUR
//  Stall bus (combinational, same cycle as request; EX has priority over ID):
//   - stallreq_ex=1               -> stall=6'b001111 (bubble into MEM)
//   - stallreq_ex=0,stallreq_id=1 -> stall=6'b000111 (bubble into EX)
//   - neither                     -> stall=6'b000000
//   - rst=1 forces stall=6'b000000 combinationally.
//  FSM (registered, state encodes the stall applied in the cycle just ended):
//   - S_RUN=2'd0, S_ID=2'd1, S_EX=2'd2; 2'd3 illegal -> S_RUN next cycle.
//   - next = stallreq_ex ? S_EX : stallreq_id ? S_ID : S_RUN, from any state.
//   - Direct S_ID<->S_EX transitions allowed; no intermediate S_RUN.
//  Instruction hold buffer (hold_q[31:0], hold_v):
//   - Edge with stall[2]=1 and hold_v=0: hold_q<=inst_sram_rdata, hold_v<=1.
//   - Edge with stall[2]=1 and hold_v=1: hold_q unchanged (first word kept).
//   - Edge with stall[2]=0 and hold_v=1: hold_v<=0 (buffer still drives ID for the
//     entire first resume cycle, then releases).
//   - id_inst = hold_v ? hold_q : inst_sram_rdata.
//   - Stall re-asserted in the resume cycle: hold_v stays 1, hold_q not recaptured.
//  Counters:
//   - cnt_id_stall += 1 on each edge where next state is S_ID; cnt_ex_stall likewise
//     for S_EX. Saturate at all-ones; never wrap.
//   - run_len (internal, clog2(TIMEOUT)+1 bits): +1 per edge with stall!=0, cleared on
//     an edge with stall==0. Counts both ID and EX stalls (no reset on switch).
//   - stall_timeout <= 1 on the edge where run_len reaches TIMEOUT; sticky until rst.
//  Reset (synchronous): state=S_RUN, hold_v=0, hold_q=0, counters=0, run_len=0,
//   stall_timeout=0. Hence id_inst=inst_sram_rdata, stall_state=0 after reset.
//   Reset mid-stall drops the held word; the pipeline restarts from PC reset.
// TESTING
//  1 reset, no requests, rdata=0x24010001 -> stall=0, id_inst=0x24010001, counters 0.
//  2 stallreq_id 1 cycle, rdata A=0x8C020000 then B=0x00000000 -> stall=6'b000111 for
//    that cycle; id_inst=A for the following cycle; cnt_id_stall=1.
//  3 stallreq_ex for 5 cycles -> stall=6'b001111 for 5 cycles, cnt_ex_stall=5,
//    stall_state=2 for those 5 cycles' next states, hold_q = word at first stall.
//  4 id and ex asserted together, then ex drops while id holds -> 6'b001111 then
//    6'b000111, state S_EX->S_ID directly, hold_q not recaptured.
//  5 stallreq_ex held TIMEOUT=64 cycles -> stall_timeout rises after 64th edge, stays
//    1 after release; only rst clears it.
//  6 PERF_W=4, 20 ex stall cycles -> cnt_ex_stall=4'hF; rst mid-stall -> all cleared.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer for the 5-stage pipeline.
// It merges the ID and EX stall requests into the per-stage stall bus.
// It holds the fetched instruction while ID is frozen, so the word is replayed on resume.
// It tracks the current stall episode in a small FSM.
// It keeps saturating stall-cycle counters and a sticky watchdog for over-long stalls.
module pipe_stall_ctrl #(
  parameter int PERF_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic [31:0]       inst_sram_rdata,
  output logic [5:0]        stall,
  output logic [31:0]       id_inst,
  output logic [1:0]        stall_state,
  output logic [PERF_W-1:0] cnt_id_stall,
  output logic [PERF_W-1:0] cnt_ex_stall,
  output logic              stall_timeout
);

  // run_len needs one bit beyond clog2 so that it can hold TIMEOUT itself.
  localparam int RUN_W = $clog2(TIMEOUT) + 1;
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [PERF_W-1:0] CNT_MAX   = '1;
  localparam logic [PERF_W-1:0] CNT_ONE   = PERF_W'(1);

  // Stall patterns: a bit set to 1 freezes that stage; the stage after the frozen ones receives a bubble.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_ID  = 2'd1,
    S_EX  = 2'd2,
    S_BAD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic [PERF_W-1:0]  cnt_id_q, cnt_id_d;
  logic [PERF_W-1:0]  cnt_ex_q, cnt_ex_d;
  logic [RUN_W-1:0]   run_len_q, run_len_d;
  logic               timeout_q, timeout_d;

  // State register: remembers which stall was applied in the cycle that just ended.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Next state: EX outranks ID. The unreachable encoding falls back to S_RUN.
  always_comb begin
    state_d = S_RUN;
    if (state_q != S_BAD) begin
      if (stallreq_ex)      state_d = S_EX;
      else if (stallreq_id) state_d = S_ID;
    end
  end

  // Outputs: the stall bus follows the requests in the same cycle. Reset forces the pipeline to run.
  always_comb begin
    stall = STALL_NONE;
    if (!rst) begin
      if (stallreq_ex)      stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;
    end
    stall_state = state_q;
  end

  // Hold buffer next state. Capture only the first word of a stall, so re-stalls keep the original word.
  // Release on the first edge with ID running, so the held word still drives ID during the resume cycle.
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    if (stall[2]) begin
      if (!hold_v_q) begin
        hold_d   = inst_sram_rdata;
        hold_v_d = 1'b1;
      end
    end else begin
      hold_v_d = 1'b0;
    end
  end

  // Hold buffer registers. A reset drops the held word, because fetch restarts from the reset PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= 32'h0;
      hold_v_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  // Counter next state. The perf counters saturate rather than wrap.
  // run_len spans ID and EX stalls alike and is capped at the limit.
  always_comb begin
    cnt_id_d = cnt_id_q;
    cnt_ex_d = cnt_ex_q;
    if (state_d == S_ID && cnt_id_q != CNT_MAX) cnt_id_d = cnt_id_q + CNT_ONE;
    if (state_d == S_EX && cnt_ex_q != CNT_MAX) cnt_ex_d = cnt_ex_q + CNT_ONE;

    run_len_d = '0;
    if (stall != STALL_NONE) begin
      run_len_d = (run_len_q == RUN_LIMIT) ? run_len_q : run_len_q + RUN_ONE;
    end

    timeout_d = timeout_q | (run_len_d == RUN_LIMIT);
  end

  // Counter and watchdog registers. The watchdog flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_id_q  <= '0;
      cnt_ex_q  <= '0;
      run_len_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_id_q  <= cnt_id_d;
      cnt_ex_q  <= cnt_ex_d;
      run_len_q <= run_len_d;
      timeout_q <= timeout_d;
    end
  end

  // ID sees the held word while a stall episode is in progress or resuming.
  always_comb begin
    id_inst       = hold_v_q ? hold_q : inst_sram_rdata;
    cnt_id_stall  = cnt_id_q;
    cnt_ex_stall  = cnt_ex_q;
    stall_timeout = timeout_q;
  end

endmodule
